rtr_packet_injector: RTL and testbench

//  Terminal-side transmitter for one router injection port: drives channel_ip_4 and consumes the credits on flow_ctrl_ip_4.

---
 rtl/rtr_packet_injector_pkg.sv | 34 +++
 rtl/rtr_credit_counter.sv | 32 +++
 rtl/rtr_packet_injector.sv | 109 ++++++++++
 tb/tb_rtr_packet_injector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtr_packet_injector_pkg.sv
// Shared constants and flit/credit layouts for the router injection-port transmitter.
// The flit struct is packed msb-first so it maps directly onto channel_out.
package rtr_packet_injector_pkg;

   localparam int NUM_VCS            = 4;
   localparam int BUFFER_SIZE        = 8;
   localparam int FLIT_DATA_WIDTH    = 64;
   localparam int MAX_PAYLOAD_LENGTH = 4;

   localparam int VC_IDX_WIDTH    = $clog2(NUM_VCS);
   localparam int LEN_WIDTH       = $clog2(MAX_PAYLOAD_LENGTH + 1);
   localparam int CNT_WIDTH       = $clog2(BUFFER_SIZE + 1);
   localparam int CHANNEL_WIDTH   = 1 + VC_IDX_WIDTH + 1 + 1 + FLIT_DATA_WIDTH;
   localparam int FLOW_CTRL_WIDTH = 1 + VC_IDX_WIDTH;

   typedef struct packed {
      logic                       valid;
      logic [VC_IDX_WIDTH-1:0]    vc;
      logic                       head;
      logic                       tail;
      logic [FLIT_DATA_WIDTH-1:0] data;
   } flit_t;

   typedef struct packed {
      logic                    valid;
      logic [VC_IDX_WIDTH-1:0] vc;
   } credit_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_t;

endpackage

// File: rtl/rtr_credit_counter.sv
// Credit counter for one VC: loads the router buffer depth at reset, decrements per
// flit sent, increments per credit returned, and flags a return that would overflow.
module rtr_credit_counter
   import rtr_packet_injector_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic avail,
   output logic sat_err
);

   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(BUFFER_SIZE);

   logic [CNT_WIDTH-1:0] count_q;

   assign avail   = (count_q != '0);
   // A send in the same cycle absorbs the returned credit, so that case never overflows.
   assign sat_err = inc & ~dec & (count_q == FULL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= FULL;
      end else if (inc && !dec && !sat_err) begin
         count_q <= count_q + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
         count_q <= count_q - CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/rtr_packet_injector.sv
// Injection-port transmitter: splits packet requests into head/body/tail flits and
// only issues a flit when the target VC holds a credit.
module rtr_packet_injector
   import rtr_packet_injector_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pkt_valid,
   output logic                       pkt_ready,
   input  logic [VC_IDX_WIDTH-1:0]    pkt_vc,
   input  logic [LEN_WIDTH-1:0]       pkt_len,
   input  logic [FLIT_DATA_WIDTH-1:0] pkt_head_data,
   input  logic                       pay_valid,
   output logic                       pay_ready,
   input  logic [FLIT_DATA_WIDTH-1:0] pay_data,
   output logic [CHANNEL_WIDTH-1:0]   channel_out,
   input  logic [FLOW_CTRL_WIDTH-1:0] flow_ctrl_in,
   output logic [NUM_VCS-1:0]         credit_avail,
   output logic                       error
);

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic [VC_IDX_WIDTH-1:0] vc_q, vc_d;
   flit_t                   flit_q, flit_d;
   logic                    issue;
   logic                    oversize;
   credit_t                 fc;
   logic [NUM_VCS-1:0]      inc, dec, sat_err;

   assign fc          = credit_t'(flow_ctrl_in);
   assign oversize    = (pkt_len > LEN_WIDTH'(MAX_PAYLOAD_LENGTH));
   assign channel_out = flit_q;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      vc_d        = vc_q;
      flit_d      = flit_q;
      flit_d.valid = 1'b0;
      pkt_ready   = 1'b0;
      pay_ready   = 1'b0;
      issue       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Oversize requests are consumed without a credit so they cannot wedge the port.
            pkt_ready = reset & pkt_valid & (oversize | credit_avail[pkt_vc]);
            if (pkt_ready && !oversize) begin
               issue        = 1'b1;
               flit_d.valid = 1'b1;
               flit_d.vc    = pkt_vc;
               flit_d.head  = 1'b1;
               flit_d.tail  = (pkt_len == '0);
               flit_d.data  = pkt_head_data;
               if (pkt_len != '0) begin
                  state_d = ST_BODY;
                  rem_d   = pkt_len;
                  vc_d    = pkt_vc;
               end
            end
         end
         ST_BODY: begin
            pay_ready = reset & credit_avail[vc_q];
            if (pay_valid && pay_ready) begin
               issue        = 1'b1;
               flit_d.valid = 1'b1;
               flit_d.vc    = vc_q;
               flit_d.head  = 1'b0;
               flit_d.tail  = (rem_q == LEN_WIDTH'(1));
               flit_d.data  = pay_data;
               rem_d        = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         vc_q    <= '0;
         flit_q  <= '0;
         error   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         vc_q    <= vc_d;
         flit_q  <= flit_d;
         error   <= error | (pkt_ready & oversize) | (|sat_err);
      end
   end

   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      assign dec[v] = issue & (flit_d.vc == VC_IDX_WIDTH'(v));
      assign inc[v] = fc.valid & (fc.vc == VC_IDX_WIDTH'(v));

      rtr_credit_counter u_cnt (
         .clk     (clk),
         .reset   (reset),
         .inc     (inc[v]),
         .dec     (dec[v]),
         .avail   (credit_avail[v]),
         .sat_err (sat_err[v])
      );
   end

endmodule

// File: tb/tb_rtr_packet_injector.sv
// Bench for rtr_packet_injector: vector table, directed credit/reset sequences and
// randomized traffic checked against a per-cycle reference model.
module tb_rtr_packet_injector;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pkt_valid = 1'b0;
   logic        pkt_ready;
   logic [1:0]  pkt_vc = '0;
   logic [2:0]  pkt_len = '0;
   logic [63:0] pkt_head_data = '0;
   logic        pay_valid = 1'b0;
   logic        pay_ready;
   logic [63:0] pay_data = '0;
   logic [68:0] channel_out;
   logic [2:0]  flow_ctrl_in = '0;
   logic [3:0]  credit_avail;
   logic        error;

   always #5 clk = ~clk;

   rtr_packet_injector dut (
      .clk           (clk),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .pkt_ready     (pkt_ready),
      .pkt_vc        (pkt_vc),
      .pkt_len       (pkt_len),
      .pkt_head_data (pkt_head_data),
      .pay_valid     (pay_valid),
      .pay_ready     (pay_ready),
      .pay_data      (pay_data),
      .channel_out   (channel_out),
      .flow_ctrl_in  (flow_ctrl_in),
      .credit_avail  (credit_avail),
      .error         (error)
   );

   int compared = 0;
   int mismatched = 0;

   // Reference model: credits per VC, sticky error, and the packet in flight.
   int          cred[4];
   bit          m_err;
   bit          m_busy;
   int          m_rem;
   int          m_vc;
   logic [63:0] m_last;

   typedef struct {
      bit pv; logic [1:0] pvc; logic [2:0] plen; logic [63:0] hd;
      bit yv; logic [63:0] pd;
      bit x_pr; bit x_yr; bit x_v; logic [1:0] x_vc; bit x_h; bit x_t; logic [63:0] x_d;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < 4; v++) cred[v] = 8;
      m_err = 0; m_busy = 0; m_rem = 0; m_vc = 0; m_last = '0;
   endtask

   // Drive one cycle of inputs, check the combinational view, advance the model and
   // check the registered flit one edge later. Called and returns at posedge+1.
   task automatic apply(input bit pv, input logic [1:0] pvc, input logic [2:0] plen,
                        input logic [63:0] hd, input bit yv, input logic [63:0] pd,
                        input bit fv, input logic [1:0] fvc, output bit o_pr, output bit o_yr);
      bit x_pr, x_yr, iss, snd, ret, ih, it;
      logic [1:0] ivc;
      logic [3:0] x_av;
      pkt_valid = pv; pkt_vc = pvc; pkt_len = plen; pkt_head_data = hd;
      pay_valid = yv; pay_data = pd; flow_ctrl_in = {fv, fvc};
      #1;
      x_pr = !m_busy && pv && (plen > 4 || cred[pvc] > 0);
      x_yr = m_busy && cred[m_vc] > 0;
      for (int v = 0; v < 4; v++) x_av[v] = (cred[v] > 0);
      o_pr = pkt_ready; o_yr = pay_ready;
      chk("pkt_ready", pkt_ready, x_pr);
      chk("pay_ready", pay_ready, x_yr);
      chk("credit_avail", credit_avail, x_av);
      chk("error", error, m_err);
      iss = 0; ivc = '0; ih = 0; it = 0;
      if (!m_busy) begin
         if (x_pr) begin
            if (plen > 4) m_err = 1;
            else begin
               iss = 1; ivc = pvc; ih = 1; it = (plen == 0); m_last = hd;
               if (plen != 0) begin m_busy = 1; m_rem = plen; m_vc = pvc; end
            end
         end
      end else if (yv && x_yr) begin
         iss = 1; ivc = 2'(m_vc); ih = 0; it = (m_rem == 1); m_last = pd;
         m_rem--;
         if (m_rem == 0) m_busy = 0;
      end
      for (int v = 0; v < 4; v++) begin
         snd = iss && (ivc == 2'(v));
         ret = fv && (fvc == 2'(v));
         if (ret && !snd) begin
            if (cred[v] == 8) m_err = 1;
            else cred[v]++;
         end else if (snd && !ret) cred[v]--;
      end
      @(posedge clk); #1;
      chk("ch_valid", channel_out[68], iss);
      chk("ch_data", channel_out[63:0], m_last);
      if (iss) begin
         chk("ch_vc", channel_out[67:66], ivc);
         chk("ch_head", channel_out[65], ih);
         chk("ch_tail", channel_out[64], it);
      end
   endtask

   task automatic do_reset();
      pkt_valid = 1; pay_valid = 1; pkt_len = '0; flow_ctrl_in = '0;
      reset = 0;
      #1;
      chk("rst_channel", channel_out, 69'h0);
      chk("rst_pkt_ready", pkt_ready, 1'b0);
      chk("rst_pay_ready", pay_ready, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_credit_avail", credit_avail, 4'hF);
      @(posedge clk); @(posedge clk); #1;
      pkt_valid = 0; pay_valid = 0;
      reset = 1;
      model_reset();
   endtask

   initial begin
      bit pr, yr;
      model_reset();
      #2;

      // Single-flit packet, then a 3-body packet with payload held valid.
      tbl[0] = '{1, 2'd2, 3'd0, 64'hA5, 0, 64'h0,   1, 0, 1, 2'd2, 1, 1, 64'hA5};
      tbl[1] = '{1, 2'd1, 3'd3, 64'h11, 1, 64'h100, 1, 0, 1, 2'd1, 1, 0, 64'h11};
      tbl[2] = '{1, 2'd1, 3'd3, 64'h22, 1, 64'h101, 0, 1, 1, 2'd1, 0, 0, 64'h101};
      tbl[3] = '{1, 2'd1, 3'd3, 64'h22, 1, 64'h102, 0, 1, 1, 2'd1, 0, 0, 64'h102};
      tbl[4] = '{1, 2'd1, 3'd3, 64'h22, 1, 64'h103, 0, 1, 1, 2'd1, 0, 1, 64'h103};
      tbl[5] = '{0, 2'd0, 3'd0, 64'h0,  0, 64'h0,   0, 0, 0, 2'd0, 0, 0, 64'h103};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply(tbl[i].pv, tbl[i].pvc, tbl[i].plen, tbl[i].hd, tbl[i].yv, tbl[i].pd, 0, 2'd0, pr, yr);
         chk("tbl_pkt_ready", pr, tbl[i].x_pr);
         chk("tbl_pay_ready", yr, tbl[i].x_yr);
         chk("tbl_valid", channel_out[68], tbl[i].x_v);
         chk("tbl_data", channel_out[63:0], tbl[i].x_d);
         if (tbl[i].x_v) begin
            chk("tbl_vc", channel_out[67:66], tbl[i].x_vc);
            chk("tbl_head", channel_out[65], tbl[i].x_h);
            chk("tbl_tail", channel_out[64], tbl[i].x_t);
         end
      end

      // Exhaust VC0, stall in BODY, then one credit resumes issue a cycle later.
      do_reset();
      for (int i = 0; i < 7; i++) apply(1, 2'd0, 3'd0, 64'(i), 0, 64'h0, 0, 2'd0, pr, yr);
      apply(1, 2'd0, 3'd1, 64'h30, 0, 64'h0, 0, 2'd0, pr, yr);
      chk("t3_avail0", credit_avail[0], 1'b0);
      apply(0, 2'd0, 3'd0, 64'h0, 1, 64'h31, 0, 2'd0, pr, yr);
      chk("t3_pay_ready_nocred", yr, 1'b0);
      chk("t3_bubble", channel_out[68], 1'b0);
      apply(0, 2'd0, 3'd0, 64'h0, 1, 64'h31, 1, 2'd0, pr, yr);
      chk("t3_pay_ready_samecyc", yr, 1'b0);
      apply(0, 2'd0, 3'd0, 64'h0, 1, 64'h31, 0, 2'd0, pr, yr);
      chk("t3_pay_ready_resume", yr, 1'b1);
      chk("t3_tail", channel_out[64], 1'b1);
      apply(1, 2'd0, 3'd0, 64'h32, 0, 64'h0, 0, 2'd0, pr, yr);
      chk("t3_pkt_ready_vc0", pr, 1'b0);
      apply(1, 2'd1, 3'd0, 64'h33, 0, 64'h0, 0, 2'd0, pr, yr);
      chk("t3_pkt_ready_vc1", pr, 1'b1);

      // Send and credit on VC3 together: count must hold, so exactly 7 more sends drain it.
      do_reset();
      apply(1, 2'd3, 3'd0, 64'h40, 0, 64'h0, 0, 2'd0, pr, yr);
      apply(1, 2'd3, 3'd0, 64'h41, 0, 64'h0, 1, 2'd3, pr, yr);
      for (int i = 1; i <= 7; i++) begin
         apply(1, 2'd3, 3'd0, 64'(i), 0, 64'h0, 0, 2'd0, pr, yr);
         chk("t4_avail3", credit_avail[3], (i < 7));
      end
      chk("t4_avail", credit_avail, 4'b0111);

      // Credit at full count, then oversize packet.
      do_reset();
      apply(0, 2'd0, 3'd0, 64'h0, 0, 64'h0, 1, 2'd1, pr, yr);
      chk("t5_err_set", error, 1'b1);
      for (int i = 1; i <= 8; i++) apply(1, 2'd1, 3'd0, 64'(i), 0, 64'h0, 0, 2'd0, pr, yr);
      chk("t5_avail1_sat", credit_avail[1], 1'b0);
      chk("t5_err_sticky", error, 1'b1);
      do_reset();
      apply(1, 2'd0, 3'd5, 64'h50, 0, 64'h0, 0, 2'd0, pr, yr);
      chk("t5_oversize_ready", pr, 1'b1);
      chk("t5_oversize_noflit", channel_out[68], 1'b0);
      chk("t5_oversize_err", error, 1'b1);

      // Reset mid-BODY with 2 flits left; do_reset checks the asynchronous clear.
      do_reset();
      apply(1, 2'd2, 3'd3, 64'hC0, 0, 64'h0, 0, 2'd0, pr, yr);
      apply(0, 2'd0, 3'd0, 64'h0, 1, 64'hC1, 0, 2'd0, pr, yr);
      do_reset();
      apply(1, 2'd2, 3'd0, 64'hD0, 1, 64'hD1, 0, 2'd0, pr, yr);
      chk("t6_pkt_ready", pr, 1'b1);
      chk("t6_pay_ready", yr, 1'b0);
      chk("t6_flit", channel_out, {1'b1, 2'd2, 1'b1, 1'b1, 64'hD0});

      // Randomized traffic; credits are returned only for flits the router could hold.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int c = 0; c < 600; c++) begin
            int v;
            bit fv;
            logic [2:0] pl;
            v  = $urandom_range(0, 3);
            fv = ($urandom_range(0, 2) != 0) && (cred[v] < 8);
            pl = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pl, {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, {$urandom, $urandom}, fv, 2'(v), pr, yr);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
